truth_table_sweeper: RTL

Sequencer for the lab's combinational logic-minimisation exercises. It walks every input combination of a function-under-test across N_IN inputs, drives them into a pair of implementations of that function (sum-of-products and product-of-sums), and compares the two outputs after a settling cycle. It reports the pass/fail result, the number of mismatches and the first failing vector. It sits between a bench or top-level start control and the combinational DUT pair, replacing hand-written stimulus sweeps.

---
 rtl/truth_table_sweeper_pkg.sv | 24 ++
 rtl/truth_table_sweeper_sweep_counter.sv | 26 ++
 rtl/truth_table_sweeper.sv | 106 ++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding, legal N_IN range and sizing helper for the truth-table sweeper.
package truth_table_sweeper_pkg;

  localparam int N_IN_MIN = 1;
  localparam int N_IN_MAX = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } sweepState_e;

  // Number of vectors in a full sweep over n inputs.
  function automatic int pow2(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector register for the sweep: clear to zero, step by one, flag the all-ones vector.
module sweep_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         incr,
  output logic [W-1:0] vec,
  output logic         last
);

  logic [W-1:0] vecReg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vecReg <= '0;
    end else if (incr) begin
      vecReg <= vecReg + W'(1);
    end
  end

  assign vec  = vecReg;
  assign last = &vecReg;

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN vectors into an SOP/POS pair and records mismatch statistics.
// Optional truth-table capture on the sig port when SWEEP_SIGNATURE_EN is defined.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sop_in,
  input  logic              pos_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [pow2(N_IN)-1:0] sig
`endif
);

  localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : gBadWidth
    $error("truth_table_sweeper: N_IN out of range");
  end

  sweepState_e   stateReg;
  logic [N_IN:0] mismatchReg;
  logic          failValidReg;
  logic [N_IN-1:0] firstFailReg;
  logic          startAccept;
  logic          stepVec;
  logic          lastVec;

  // A start is honoured only while the sweeper is not running.
  assign startAccept = start && (stateReg == IDLE || stateReg == DONE);
  assign stepVec     = (stateReg == SAMPLE) && !lastVec;

  sweep_counter #(.W(N_IN)) uCounter (
    .clk   (clk),
    .rst   (rst),
    .clear (startAccept),
    .incr  (stepVec),
    .vec   (vec_out),
    .last  (lastVec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg     <= IDLE;
      mismatchReg  <= '0;
      failValidReg <= 1'b0;
      firstFailReg <= '0;
    end else begin
      case (stateReg)
        IDLE, DONE: begin
          if (startAccept) begin
            mismatchReg  <= '0;
            failValidReg <= 1'b0;
            firstFailReg <= '0;
            stateReg     <= DRIVE;
          end
        end
        DRIVE: stateReg <= SAMPLE;
        SAMPLE: begin
          if (sop_in != pos_in) begin
            mismatchReg <= mismatchReg + CNT_ONE;
            if (!failValidReg) begin
              firstFailReg <= vec_out;
              failValidReg <= 1'b1;
            end
          end
          stateReg <= lastVec ? DONE : DRIVE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  logic [pow2(N_IN)-1:0] sigReg;

  always_ff @(posedge clk) begin
    if (rst || startAccept) begin
      sigReg <= '0;
    end else if (stateReg == SAMPLE) begin
      sigReg[vec_out] <= sop_in;
    end
  end

  assign sig = sigReg;
`endif

  assign busy         = (stateReg == DRIVE) || (stateReg == SAMPLE);
  assign done         = (stateReg == DONE);
  assign pass         = done && (mismatchReg == '0);
  assign mismatch_cnt = mismatchReg;
  assign fail_valid   = failValidReg;
  assign first_fail   = firstFailReg;

endmodule
